// File: rtl/char_position_ctrl.sv
// rtl/char_position_ctrl.sv - player position / attack controller driven by per-frame move ticks
//
// Ports:
//   clock            sole clock, all state on rising edge
//   reset            asynchronous active-low reset
//   move_tick        one-cycle pulse per game frame requesting an action
//   dir_in[2:0]      requested action (NO_ACTION/ATTACK/UP/DOWN/LEFT/RIGHT)
//   map_collision    player/map collision flag for the probed step
//   enemy_collision  player/enemy overlap flag
//   char_x[8:0]      player x
//   char_y[7:0]      player y
//   direction_char   direction presented to the collision detector
//   facing_char      last movement direction
//   collision_enable high while the collision detector is being probed (CHECK)
//   attacking        high while an attack is in progress
//   hit_pulse        one-cycle pulse when the player touched the enemy while not attacking
//   busy             high whenever the controller is not idle
module char_position_ctrl #(
  parameter logic [8:0]  START_X       = 9'd152,
  parameter logic [7:0]  START_Y       = 8'd112,
  parameter logic [8:0]  MAX_X         = 9'd303,
  parameter logic [7:0]  MAX_Y         = 8'd223,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  ATTACK_CYCLES = 8'd20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       move_tick,
  input  logic [2:0] dir_in,
  input  logic       map_collision,
  input  logic       enemy_collision,
  output logic [8:0] char_x,
  output logic [7:0] char_y,
  output logic [2:0] direction_char,
  output logic [2:0] facing_char,
  output logic       collision_enable,
  output logic       attacking,
  output logic       hit_pulse,
  output logic       busy
);

  localparam logic [2:0] DIR_NONE   = 3'b000;
  localparam logic [2:0] DIR_ATTACK = 3'b001;
  localparam logic [2:0] DIR_UP     = 3'b010;
  localparam logic [2:0] DIR_DOWN   = 3'b011;
  localparam logic [2:0] DIR_LEFT   = 3'b100;
  localparam logic [2:0] DIR_RIGHT  = 3'b101;

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_MOVE   = 2'd2,
    ST_ATTACK = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [2:0] settle_cnt, settle_cnt_n;
  logic [7:0] attack_cnt, attack_cnt_n;
  logic       map_flag, map_flag_n;
  logic       enemy_flag, enemy_flag_n;
  logic [8:0] char_x_n;
  logic [7:0] char_y_n;
  logic [2:0] direction_n;
  logic [2:0] facing_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      settle_cnt     <= 3'd0;
      attack_cnt     <= 8'd0;
      map_flag       <= 1'b0;
      enemy_flag     <= 1'b0;
      char_x         <= START_X;
      char_y         <= START_Y;
      direction_char <= DIR_NONE;
      facing_char    <= DIR_DOWN;
    end else begin
      state          <= state_n;
      settle_cnt     <= settle_cnt_n;
      attack_cnt     <= attack_cnt_n;
      map_flag       <= map_flag_n;
      enemy_flag     <= enemy_flag_n;
      char_x         <= char_x_n;
      char_y         <= char_y_n;
      direction_char <= direction_n;
      facing_char    <= facing_n;
    end
  end

  always_comb begin
    state_n      = state;
    settle_cnt_n = settle_cnt;
    attack_cnt_n = attack_cnt;
    map_flag_n   = map_flag;
    enemy_flag_n = enemy_flag;
    char_x_n     = char_x;
    char_y_n     = char_y;
    direction_n  = direction_char;
    facing_n     = facing_char;

    case (state)
      ST_IDLE: begin
        if (move_tick) begin
          case (dir_in)
            DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT: begin
              direction_n  = dir_in;
              settle_cnt_n = 3'd0;
              state_n      = ST_CHECK;
            end
            DIR_ATTACK: begin
              direction_n  = DIR_ATTACK;
              attack_cnt_n = ATTACK_CYCLES - 8'd1;
              state_n      = ST_ATTACK;
            end
            default: direction_n = DIR_NONE;
          endcase
        end
      end

      // The collision flags are only trusted once the levelmap ROM has had
      // SETTLE_CYCLES extra clocks to respond to the new probe direction.
      ST_CHECK: begin
        if (settle_cnt == SETTLE_LAST) begin
          map_flag_n   = map_collision;
          enemy_flag_n = enemy_collision;
          state_n      = ST_MOVE;
        end else begin
          settle_cnt_n = settle_cnt + 3'd1;
        end
      end

      // Facing follows the request even when the step itself is blocked.
      ST_MOVE: begin
        state_n  = ST_IDLE;
        facing_n = direction_char;
        if (!map_flag) begin
          case (direction_char)
            DIR_UP:    if (char_y != 8'd0) char_y_n = char_y - 8'd1;
            DIR_DOWN:  if (char_y < MAX_Y) char_y_n = char_y + 8'd1;
            DIR_LEFT:  if (char_x != 9'd0) char_x_n = char_x - 9'd1;
            DIR_RIGHT: if (char_x < MAX_X) char_x_n = char_x + 9'd1;
            default: ;
          endcase
        end
      end

      ST_ATTACK: begin
        if (attack_cnt == 8'd0) begin
          state_n = ST_IDLE;
        end else begin
          attack_cnt_n = attack_cnt - 8'd1;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign collision_enable = (state == ST_CHECK);
  assign attacking        = (state == ST_ATTACK);
  assign hit_pulse        = (state == ST_MOVE) && enemy_flag;
  assign busy             = (state != ST_IDLE);

endmodule

// File: tb/tb_char_position_ctrl.sv
// tb/tb_char_position_ctrl.sv - self-checking bench for char_position_ctrl
module tb_char_position_ctrl;

  localparam logic [2:0] NONE   = 3'b000;
  localparam logic [2:0] ATTACK = 3'b001;
  localparam logic [2:0] UP     = 3'b010;
  localparam logic [2:0] DOWN   = 3'b011;
  localparam logic [2:0] LEFT   = 3'b100;
  localparam logic [2:0] RIGHT  = 3'b101;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       move_tick = 1'b0;
  logic [2:0] dir_in = 3'b000;
  logic       map_collision = 1'b0;
  logic       enemy_collision = 1'b0;
  logic [8:0] char_x;
  logic [7:0] char_y;
  logic [2:0] direction_char;
  logic [2:0] facing_char;
  logic       collision_enable;
  logic       attacking;
  logic       hit_pulse;
  logic       busy;

  int checks = 0;
  int failures = 0;

  char_position_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .move_tick        (move_tick),
    .dir_in           (dir_in),
    .map_collision    (map_collision),
    .enemy_collision  (enemy_collision),
    .char_x           (char_x),
    .char_y           (char_y),
    .direction_char   (direction_char),
    .facing_char      (facing_char),
    .collision_enable (collision_enable),
    .attacking        (attacking),
    .hit_pulse        (hit_pulse),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Issues one movement tick; collision inputs are held at the opposite value
  // except during the final CHECK cycle so early sampling would be visible.
  task automatic do_action(input logic [2:0] d, input logic m, input logic e,
                           output int ce_n, output int hits, output int idle_at,
                           output logic early);
    logic [8:0] x0;
    logic [7:0] y0;
    ce_n = 0; hits = 0; idle_at = -1; early = 1'b0;
    @(negedge clock);
    x0 = char_x; y0 = char_y;
    move_tick = 1'b1; dir_in = d; map_collision = ~m; enemy_collision = ~e;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      move_tick = 1'b0; dir_in = NONE;
      map_collision = ~m; enemy_collision = ~e;
      if (collision_enable) begin
        ce_n++;
        if (ce_n == 3) begin
          map_collision = m; enemy_collision = e;
        end
      end
      if (hit_pulse) hits++;
      if (k <= 4 && (char_x !== x0 || char_y !== y0)) early = 1'b1;
      if (!busy) begin
        idle_at = k;
        break;
      end
    end
    map_collision = 1'b0; enemy_collision = 1'b0;
  endtask

  typedef struct {
    logic [2:0] dir;
    logic       map;
    logic       enemy;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] facing;
    int         hits;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int ce_n, hits, idle_at, att, bad_dir, n;
    logic early, moved;
    logic [8:0] x0;
    logic [7:0] y0;

    vecs[0] = '{RIGHT, 1'b0, 1'b0, 9'd153, 8'd112, RIGHT, 0};
    vecs[1] = '{UP,    1'b1, 1'b0, 9'd153, 8'd112, UP,    0};
    vecs[2] = '{LEFT,  1'b0, 1'b1, 9'd152, 8'd112, LEFT,  1};
    vecs[3] = '{DOWN,  1'b0, 1'b0, 9'd152, 8'd113, DOWN,  0};
    vecs[4] = '{UP,    1'b0, 1'b0, 9'd152, 8'd112, UP,    0};
    vecs[5] = '{DOWN,  1'b1, 1'b1, 9'd152, 8'd112, DOWN,  1};

    // Reset values while reset is held low
    repeat (3) @(negedge clock);
    check("rst_x", char_x, 152);
    check("rst_y", char_y, 112);
    check("rst_dir", direction_char, NONE);
    check("rst_facing", facing_char, DOWN);
    check("rst_ce", collision_enable, 0);
    check("rst_att", attacking, 0);
    check("rst_hit", hit_pulse, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      do_action(vecs[i].dir, vecs[i].map, vecs[i].enemy, ce_n, hits, idle_at, early);
      check($sformatf("vec%0d_x", i), char_x, vecs[i].x);
      check($sformatf("vec%0d_y", i), char_y, vecs[i].y);
      check($sformatf("vec%0d_facing", i), facing_char, vecs[i].facing);
      check($sformatf("vec%0d_hits", i), hits, vecs[i].hits);
      check($sformatf("vec%0d_ce_cycles", i), ce_n, 3);
      check($sformatf("vec%0d_idle_at", i), idle_at, 5);
      check($sformatf("vec%0d_early_update", i), early, 0);
    end

    // NO_ACTION and reserved codes stay idle and clear direction_char
    @(negedge clock); move_tick = 1'b1; dir_in = 3'b110;
    @(negedge clock); move_tick = 1'b0; dir_in = NONE;
    check("noact_busy", busy, 0);
    check("noact_dir", direction_char, NONE);
    check("noact_x", char_x, 152);

    // Left boundary
    n = 0;
    while (char_x != 0 && n < 400) begin
      do_action(LEFT, 1'b0, 1'b0, ce_n, hits, idle_at, early);
      n++;
    end
    check("left_steps", n, 152);
    do_action(LEFT, 1'b0, 1'b0, ce_n, hits, idle_at, early);
    check("left_clamp_x", char_x, 0);
    check("left_clamp_facing", facing_char, LEFT);

    // Right boundary
    n = 0;
    while (char_x != 303 && n < 400) begin
      do_action(RIGHT, 1'b0, 1'b0, ce_n, hits, idle_at, early);
      n++;
    end
    check("right_steps", n, 303);
    do_action(RIGHT, 1'b0, 1'b0, ce_n, hits, idle_at, early);
    check("right_clamp_x", char_x, 303);

    // Top and bottom boundaries
    n = 0;
    while (char_y != 0 && n < 300) begin
      do_action(UP, 1'b0, 1'b0, ce_n, hits, idle_at, early);
      n++;
    end
    check("up_steps", n, 112);
    do_action(UP, 1'b0, 1'b0, ce_n, hits, idle_at, early);
    check("up_clamp_y", char_y, 0);
    n = 0;
    while (char_y != 223 && n < 300) begin
      do_action(DOWN, 1'b0, 1'b0, ce_n, hits, idle_at, early);
      n++;
    end
    check("down_steps", n, 223);
    do_action(DOWN, 1'b0, 1'b0, ce_n, hits, idle_at, early);
    check("down_clamp_y", char_y, 223);
    check("down_clamp_x", char_x, 303);

    // Attack with a DOWN tick arriving mid-attack
    @(negedge clock);
    x0 = char_x; y0 = char_y;
    move_tick = 1'b1; dir_in = ATTACK;
    att = 0; bad_dir = 0; hits = 0; moved = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      move_tick = (k == 5);
      dir_in = (k == 5) ? DOWN : NONE;
      if (attacking) begin
        att++;
        if (direction_char !== ATTACK) bad_dir++;
      end
      if (hit_pulse) hits++;
      if (char_x !== x0 || char_y !== y0) moved = 1'b1;
    end
    check("attack_cycles", att, 20);
    check("attack_dir", bad_dir, 0);
    check("attack_hits", hits, 0);
    check("attack_moved", moved, 0);
    check("attack_busy_after", busy, 0);
    check("attack_dir_after", direction_char, ATTACK);

    // Reset asserted mid-CHECK
    @(negedge clock); move_tick = 1'b1; dir_in = RIGHT;
    @(negedge clock); move_tick = 1'b0; dir_in = NONE;
    check("midrst_in_check", collision_enable, 1);
    #2 reset = 1'b0;
    #1;
    check("midrst_x", char_x, 152);
    check("midrst_y", char_y, 112);
    check("midrst_dir", direction_char, NONE);
    check("midrst_facing", facing_char, DOWN);
    check("midrst_ce", collision_enable, 0);
    check("midrst_busy", busy, 0);
    @(negedge clock); reset = 1'b1;
    repeat (6) @(negedge clock);
    check("postrst_no_step_x", char_x, 152);
    check("postrst_busy", busy, 0);
    do_action(RIGHT, 1'b0, 1'b0, ce_n, hits, idle_at, early);
    check("postrst_move_x", char_x, 153);
    check("postrst_move_facing", facing_char, RIGHT);
    check("postrst_idle_at", idle_at, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
